// File: rtl/ee201_detour_monitor.sv
// Receiving-end checker for the detour-sign lamp bus: decodes GLL/GL/GR/GRR back to a
// sign state, tracks direction, flags illegal steps and stalls, and counts protocol errors.
module ee201_detour_monitor #(
    parameter int HOLD_MAX = 4,
    parameter int CNT_W    = 8
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             GLL,
    input  logic             GL,
    input  logic             GR,
    input  logic             GRR,
    input  logic             clear_err,
    output logic             sync,
    output logic             dir_valid,
    output logic             L_Rbar_det,
    output logic             seq_done,
    output logic             err,
    output logic             stall,
    output logic [CNT_W-1:0] err_count
);

    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX);

    localparam logic [0:0] ST_SYNC  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    // Each legal pattern maps to a side and a position in its 3-step sequence (0 = I).
    typedef struct packed {
        logic       legal;
        logic       left;
        logic [1:0] pos;
    } lamp_code_t;

    function automatic lamp_code_t decode(input logic [3:0] p);
        case (p)
            4'b0000: decode = '{legal: 1'b1, left: 1'b0, pos: 2'd0};
            4'b0010: decode = '{legal: 1'b1, left: 1'b0, pos: 2'd1};
            4'b0011: decode = '{legal: 1'b1, left: 1'b0, pos: 2'd2};
            4'b0111: decode = '{legal: 1'b1, left: 1'b0, pos: 2'd3};
            4'b0100: decode = '{legal: 1'b1, left: 1'b1, pos: 2'd1};
            4'b1100: decode = '{legal: 1'b1, left: 1'b1, pos: 2'd2};
            4'b1110: decode = '{legal: 1'b1, left: 1'b1, pos: 2'd3};
            default: decode = '{legal: 1'b0, left: 1'b0, pos: 2'd0};
        endcase
    endfunction

    logic [0:0]       state, state_nx;
    logic [3:0]       prev;
    logic [HW-1:0]    hold_cnt, hold_nx;
    logic             dv_nx, dl_nx, done_nx, err_nx, stall_nx;
    logic [CNT_W-1:0] count_nx;

    logic [3:0]  cur;
    lamp_code_t  cd, pd;
    logic        step_ok;

    assign cur  = {GLL, GL, GR, GRR};
    assign cd   = decode(cur);
    assign pd   = decode(prev);
    assign sync = (state == ST_TRACK);

    always_comb begin
        if (!(cd.legal && pd.legal))
            step_ok = 1'b0;
        else if (cd.pos == 2'd0)
            step_ok = (pd.pos == 2'd3);
        else if (pd.pos == 2'd0)
            step_ok = (cd.pos == 2'd1);
        else
            step_ok = (cd.left == pd.left) && (cd.pos == pd.pos + 2'd1);
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_nx = state;
        hold_nx  = hold_cnt;
        dv_nx    = dir_valid;
        dl_nx    = L_Rbar_det;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        stall_nx = 1'b0;

        case (state)
            ST_SYNC: begin
                hold_nx = '0;
                if (cur == 4'b0000) state_nx = ST_TRACK;
            end
            ST_TRACK: begin
                if (!cd.legal) begin
                    err_nx = 1'b1;
                end else if (cur == prev) begin
                    // Holding I never stalls; other patterns may repeat HOLD_MAX times.
                    if (cd.pos != 2'd0) begin
                        if (hold_cnt == HOLD_LIM) begin
                            err_nx   = 1'b1;
                            stall_nx = 1'b1;
                        end else begin
                            hold_nx = hold_cnt + HW'(1);
                        end
                    end
                end else if (step_ok) begin
                    hold_nx = '0;
                    if (cd.pos == 2'd1) begin
                        dv_nx = 1'b1;
                        dl_nx = cd.left;
                    end
                    if (cd.pos == 2'd0) done_nx = 1'b1;
                end else begin
                    err_nx = 1'b1;
                end

                if (err_nx) begin
                    state_nx = ST_SYNC;
                    dv_nx    = 1'b0;
                    hold_nx  = '0;
                end
            end
            default: state_nx = ST_SYNC;
        endcase

        // A clear and an error in the same cycle leaves exactly one error counted.
        if (clear_err)
            count_nx = {{(CNT_W-1){1'b0}}, err_nx};
        else if (err_nx && (err_count != {CNT_W{1'b1}}))
            count_nx = err_count + CNT_W'(1);
        else
            count_nx = err_count;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_SYNC;
            prev       <= 4'b0000;
            hold_cnt   <= '0;
            dir_valid  <= 1'b0;
            L_Rbar_det <= 1'b0;
            seq_done   <= 1'b0;
            err        <= 1'b0;
            stall      <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_nx;
            prev       <= cur;
            hold_cnt   <= hold_nx;
            dir_valid  <= dv_nx;
            L_Rbar_det <= dl_nx;
            seq_done   <= done_nx;
            err        <= err_nx;
            stall      <= stall_nx;
            err_count  <= count_nx;
        end
    end

endmodule

// File: tb/tb_ee201_detour_monitor.sv
// Self-checking bench for ee201_detour_monitor: directed scenarios plus a random lamp walk,
// all compared against a sequence-table reference model.
module tb_ee201_detour_monitor;

    localparam int HOLD_MAX = 4;
    localparam int CNT_W    = 8;

    localparam logic [3:0] R_SEQ [4] = '{4'b0000, 4'b0010, 4'b0011, 4'b0111};
    localparam logic [3:0] L_SEQ [4] = '{4'b0000, 4'b0100, 4'b1100, 4'b1110};

    logic             Clk = 1'b0;
    logic             reset = 1'b0;
    logic             GLL = 1'b0, GL = 1'b0, GR = 1'b0, GRR = 1'b0;
    logic             clear_err = 1'b0;
    logic             sync, dir_valid, L_Rbar_det, seq_done, err, stall;
    logic [CNT_W-1:0] err_count;

    int checks   = 0;
    int failures = 0;
    int done_seen = 0;
    int err_seen  = 0;

    // Reference model state
    bit         m_locked;
    bit         m_dir_valid;
    bit         m_left;
    logic [3:0] m_prev;
    int         m_repeats;
    int         m_count;
    bit         e_done, e_err, e_stall;

    ee201_detour_monitor #(.HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
        .Clk(Clk), .reset(reset),
        .GLL(GLL), .GL(GL), .GR(GR), .GRR(GRR),
        .clear_err(clear_err),
        .sync(sync), .dir_valid(dir_valid), .L_Rbar_det(L_Rbar_det),
        .seq_done(seq_done), .err(err), .stall(stall), .err_count(err_count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit on_table(input logic [3:0] p);
        for (int i = 0; i < 4; i++)
            if (R_SEQ[i] == p || L_SEQ[i] == p) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit is_next(input logic [3:0] a, input logic [3:0] b);
        for (int i = 0; i < 4; i++) begin
            if (R_SEQ[i] == a && R_SEQ[(i+1)%4] == b) return 1'b1;
            if (L_SEQ[i] == a && L_SEQ[(i+1)%4] == b) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [3:0] next_of(input logic [3:0] p, input bit pick_left);
        if (p == 4'b0000) return pick_left ? L_SEQ[1] : R_SEQ[1];
        for (int i = 1; i < 4; i++) begin
            if (R_SEQ[i] == p) return R_SEQ[(i+1)%4];
            if (L_SEQ[i] == p) return L_SEQ[(i+1)%4];
        end
        return 4'b0000;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_dir_valid = 0; m_left = 0; m_prev = 4'b0000;
        m_repeats = 0; m_count = 0; e_done = 0; e_err = 0; e_stall = 0;
    endtask

    task automatic model_update(input logic [3:0] cur, input bit clr);
        e_done = 0; e_err = 0; e_stall = 0;
        if (!m_locked) begin
            if (cur == 4'b0000) m_locked = 1;
            m_repeats = 0;
        end else if (!on_table(cur)) begin
            e_err = 1;
        end else if (cur == m_prev) begin
            if (cur != 4'b0000) begin
                if (m_repeats >= HOLD_MAX) begin
                    e_err = 1; e_stall = 1;
                end else begin
                    m_repeats++;
                end
            end
        end else if (is_next(m_prev, cur)) begin
            m_repeats = 0;
            if (cur == R_SEQ[1]) begin m_dir_valid = 1; m_left = 0; end
            if (cur == L_SEQ[1]) begin m_dir_valid = 1; m_left = 1; end
            if (cur == 4'b0000) e_done = 1;
        end else begin
            e_err = 1;
        end
        if (e_err) begin
            m_locked = 0; m_dir_valid = 0; m_repeats = 0;
        end
        if (clr) m_count = e_err ? 1 : 0;
        else if (e_err && m_count < 255) m_count++;
        m_prev = cur;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".sync"},      32'(sync),      32'(m_locked));
        check({tag, ".dir_valid"}, 32'(dir_valid), 32'(m_dir_valid));
        if (m_dir_valid) check({tag, ".L_Rbar_det"}, 32'(L_Rbar_det), 32'(m_left));
        check({tag, ".seq_done"},  32'(seq_done),  32'(e_done));
        check({tag, ".err"},       32'(err),       32'(e_err));
        check({tag, ".stall"},     32'(stall),     32'(e_stall));
        check({tag, ".err_count"}, 32'(err_count), 32'(m_count));
        if (seq_done === 1'b1) done_seen++;
        if (err === 1'b1) err_seen++;
    endtask

    task automatic step(input string tag, input logic [3:0] p, input bit clr);
        @(negedge Clk);
        {GLL, GL, GR, GRR} = p;
        clear_err = clr;
        @(posedge Clk);
        model_update(p, clr);
        #1 check_all(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".sync"},       32'(sync),       32'd0);
        check({tag, ".dir_valid"},  32'(dir_valid),  32'd0);
        check({tag, ".L_Rbar_det"}, 32'(L_Rbar_det), 32'd0);
        check({tag, ".seq_done"},   32'(seq_done),   32'd0);
        check({tag, ".err"},        32'(err),        32'd0);
        check({tag, ".stall"},      32'(stall),      32'd0);
        check({tag, ".err_count"},  32'(err_count),  32'd0);
    endtask

    initial begin
        logic [3:0] pat;
        int r;

        model_reset();
        #12;
        check_zero("reset_init");
        @(negedge Clk) reset = 1'b1;

        // Reset in the middle of a sequence
        step("pre_i",   4'b0000, 0);
        step("pre_r1",  4'b0010, 0);
        step("pre_r12", 4'b0011, 0);
        @(negedge Clk);
        #2 reset = 1'b0;
        #1 check_zero("reset_mid");
        model_reset();
        @(negedge Clk) reset = 1'b1;
        step("post_rst_r1", 4'b0010, 0);
        step("post_rst_i",  4'b0000, 0);

        // Full R sequence
        done_seen = 0;
        step("r_i",    4'b0000, 0);
        step("r_r1",   4'b0010, 0);
        step("r_r12",  4'b0011, 0);
        step("r_r123", 4'b0111, 0);
        step("r_done", 4'b0000, 0);
        check("r_done_count", done_seen, 1);

        // L then R: direction flips via I
        done_seen = 0; err_seen = 0;
        step("l_l1",   4'b0100, 0);
        step("l_l12",  4'b1100, 0);
        step("l_l123", 4'b1110, 0);
        step("l_done", 4'b0000, 0);
        step("lr_r1",  4'b0010, 0);
        step("lr_r12", 4'b0011, 0);
        step("lr_r123",4'b0111, 0);
        step("lr_done",4'b0000, 0);
        check("lr_done_count", done_seen, 2);
        check("lr_err_count", err_seen, 0);

        // Illegal pattern, then relock
        step("ill_1001", 4'b1001, 0);
        step("ill_after",4'b1001, 0);
        step("relock",   4'b0000, 0);

        // Skipped step
        step("skip_r1",  4'b0010, 0);
        step("skip_bad", 4'b0111, 0);
        step("skip_i",   4'b0000, 0);

        // Stall on the sixth sample of R12
        step("st_r1", 4'b0010, 0);
        for (int i = 0; i < HOLD_MAX + 2; i++) step("st_hold", 4'b0011, 0);
        check("stall_seen", 32'(stall), 32'd1);
        step("st_i", 4'b0000, 0);

        // Saturate the error counter
        for (int i = 0; i < 260; i++) begin
            step("sat_i",   4'b0000, 0);
            step("sat_bad", 4'b1001, 0);
        end
        check("sat_ff", 32'(err_count), 32'hFF);
        step("clr_i",   4'b0000, 0);
        step("clr_err", 4'b1001, 1);
        step("clr_only",4'b0000, 1);

        // Random walk biased toward legal sequences
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      pat = next_of(m_prev, bit'($urandom_range(0, 1)));
            else if (r < 80) pat = m_prev;
            else if (r < 90) pat = 4'b0000;
            else             pat = 4'($urandom_range(0, 15));
            step("rand", pat, $urandom_range(0, 99) < 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
